// File: rtl/emissor.sv
// emissor: requester-side MESI controller for one cache line; define EMISSOR_EXCL_EN for full MESI (E fill), otherwise MSI.
module emissor #(
  parameter int TAG_W = 8
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic             CPU_valid,
  input  logic             CPU_wr,
  input  logic [TAG_W-1:0] CPU_tag,
  output logic             CPU_ready,
  output logic             BUS_req,
  input  logic             BUS_gnt,
  output logic [2:0]       BUS_cmd,
  output logic [TAG_W-1:0] BUS_addr,
  input  logic             BUS_done,
  input  logic             BUS_shared,
  input  logic             SNP_inv,
  input  logic             SNP_shr,
  output logic [2:0]       state,
  output logic [TAG_W-1:0] tag
);
`ifdef EMISSOR_EXCL_EN
  localparam logic EXCL = 1'b1;
`else
  localparam logic EXCL = 1'b0;
`endif
  localparam logic [2:0] ST_I = 3'b001, ST_S = 3'b010, ST_E = 3'b011, ST_M = 3'b100;
  localparam logic [2:0] C_NONE = 3'b000, C_RM = 3'b001, C_WM = 3'b010, C_UPG = 3'b011, C_WB = 3'b100;
  typedef enum logic [2:0] {IDLE, WB_ARB, WB_XFER, ARB, XFER, RESP} fsm_t;
  fsm_t             fsm_q, fsm_d;
  logic [2:0]       st_q, st_d, cmd_q, cmd_d, snp_st, fill;
  logic [TAG_W-1:0] tag_q, tag_d, addr_q, addr_d;
  logic             hit;
  logic [2:0]       miss_cmd;
  // line state, tag, bus command and controller state registers
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      fsm_q  <= IDLE;
      st_q   <= ST_I;
      tag_q  <= '0;
      cmd_q  <= C_NONE;
      addr_q <= '0;
    end else begin
      fsm_q  <= fsm_d;
      st_q   <= st_d;
      tag_q  <= tag_d;
      cmd_q  <= cmd_d;
      addr_q <= addr_d;
    end
  end
  // next state: snoops resolve first so a same-cycle request sees the downgraded line
  always_comb begin
    fsm_d    = fsm_q;
    st_d     = st_q;
    tag_d    = tag_q;
    cmd_d    = cmd_q;
    addr_d   = addr_q;
    snp_st   = SNP_inv ? ST_I : (SNP_shr && (st_q == ST_E || st_q == ST_M)) ? ST_S : st_q;
    hit      = (snp_st != ST_I) && (tag_q == CPU_tag);
    miss_cmd = CPU_wr ? C_WM : C_RM;
    fill     = (EXCL && !BUS_shared) ? ST_E : ST_S;
    case (fsm_q)
      IDLE: begin
        st_d = snp_st;
        if (CPU_valid) begin
          if (hit && (!CPU_wr || snp_st == ST_M)) fsm_d = RESP;
          else if (hit && snp_st == ST_E) begin
            st_d  = ST_M;
            fsm_d = RESP;
          end else if (hit) begin
            cmd_d  = C_UPG;
            addr_d = CPU_tag;
            fsm_d  = ARB;
          end else if (snp_st == ST_M) begin
            cmd_d  = C_WB;
            addr_d = tag_q;
            fsm_d  = WB_ARB;
          end else begin
            cmd_d  = miss_cmd;
            addr_d = CPU_tag;
            fsm_d  = ARB;
          end
        end
      end
      WB_ARB: fsm_d = BUS_gnt ? WB_XFER : WB_ARB;
      WB_XFER: if (BUS_done) begin
        st_d   = ST_I;
        cmd_d  = miss_cmd;
        addr_d = CPU_tag;
        fsm_d  = ARB;
      end
      ARB: begin
        if (cmd_q == C_UPG && SNP_inv) begin
          st_d  = ST_I;
          cmd_d = C_WM;
        end
        fsm_d = BUS_gnt ? XFER : ARB;
      end
      XFER: if (BUS_done) begin
        st_d  = (cmd_q == C_RM) ? fill : ST_M;
        tag_d = CPU_tag;
        cmd_d = C_NONE;
        fsm_d = RESP;
      end
      RESP: fsm_d = IDLE;
      default: fsm_d = IDLE;
    endcase
  end
  // outputs decoded from controller state and registers
  always_comb begin
    BUS_req   = (fsm_q == ARB) || (fsm_q == WB_ARB);
    CPU_ready = (fsm_q == RESP);
    BUS_cmd   = cmd_q;
    BUS_addr  = addr_q;
    state     = st_q;
    tag       = tag_q;
  end
endmodule

// File: tb/tb_emissor.sv
// tb_emissor: directed transaction table plus hand sequences for snoop races, reset and back-to-back hits.
module tb_emissor;
`ifdef EMISSOR_EXCL_EN
  localparam logic [2:0] RD_FILL = 3'b011, WRE_CMD = 3'b000;
`else
  localparam logic [2:0] RD_FILL = 3'b010, WRE_CMD = 3'b011;
`endif
  logic       CLK = 0, CLR = 0, CPU_valid = 0, CPU_wr = 0, BUS_gnt = 0, BUS_done = 0;
  logic       BUS_shared = 0, SNP_inv = 0, SNP_shr = 0;
  logic [7:0] CPU_tag = 0;
  logic       CPU_ready, BUS_req;
  logic [2:0] BUS_cmd, state;
  logic [7:0] BUS_addr, tag;
  int checks = 0, errors = 0;
  typedef struct {
    logic       wr;
    logic [7:0] t;
    logic       sh;
    logic       wb;
    logic [7:0] wa;
    logic [2:0] cmd;
    logic [2:0] st;
  } vec_t;
  vec_t tbl[9];
  vec_t v;

  emissor #(.TAG_W(8)) dut (
    .CLK(CLK), .CLR(CLR), .CPU_valid(CPU_valid), .CPU_wr(CPU_wr), .CPU_tag(CPU_tag),
    .CPU_ready(CPU_ready), .BUS_req(BUS_req), .BUS_gnt(BUS_gnt), .BUS_cmd(BUS_cmd),
    .BUS_addr(BUS_addr), .BUS_done(BUS_done), .BUS_shared(BUS_shared), .SNP_inv(SNP_inv),
    .SNP_shr(SNP_shr), .state(state), .tag(tag)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %0h want %0h", n, a, e);
    end
  endtask

  task automatic xact(input vec_t x);
    CPU_valid = 1; CPU_wr = x.wr; CPU_tag = x.t;
    @(negedge CLK);
    if (x.wb) begin
      chk("wb_req", BUS_req, 1);
      chk("wb_cmd", BUS_cmd, 3'b100);
      chk("wb_addr", BUS_addr, x.wa);
      BUS_gnt = 1;
      @(negedge CLK);
      BUS_gnt = 0; BUS_done = 1;
      @(negedge CLK);
      BUS_done = 0;
      chk("wb_state", state, 3'b001);
    end
    if (x.cmd != 3'b000) begin
      chk("req", BUS_req, 1);
      chk("cmd", BUS_cmd, x.cmd);
      chk("addr", BUS_addr, x.t);
      repeat (2) @(negedge CLK);
      chk("req_hold", BUS_req, 1);
      chk("cmd_hold", BUS_cmd, x.cmd);
      BUS_gnt = 1;
      @(negedge CLK);
      BUS_gnt = 0;
      chk("req_drop", BUS_req, 0);
      BUS_done = 1; BUS_shared = x.sh;
      @(negedge CLK);
      BUS_done = 0; BUS_shared = 0;
      chk("cmd_clear", BUS_cmd, 3'b000);
    end else chk("hit_noreq", BUS_req, 0);
    chk("ready", CPU_ready, 1);
    chk("state", state, x.st);
    chk("tag", tag, x.t);
    CPU_valid = 0;
    @(negedge CLK);
    chk("ready_pulse", CPU_ready, 0);
  endtask

  initial begin
    tbl[0] = '{1'b0, 8'h12, 1'b0, 1'b0, 8'h00, 3'b001, RD_FILL};
    tbl[1] = '{1'b1, 8'h12, 1'b0, 1'b0, 8'h00, WRE_CMD, 3'b100};
    tbl[2] = '{1'b0, 8'h34, 1'b0, 1'b1, 8'h12, 3'b001, RD_FILL};
    tbl[3] = '{1'b0, 8'h34, 1'b0, 1'b0, 8'h00, 3'b000, RD_FILL};
    tbl[4] = '{1'b0, 8'h56, 1'b1, 1'b0, 8'h00, 3'b001, 3'b010};
    tbl[5] = '{1'b1, 8'h56, 1'b0, 1'b0, 8'h00, 3'b011, 3'b100};
    tbl[6] = '{1'b1, 8'h56, 1'b0, 1'b0, 8'h00, 3'b000, 3'b100};
    tbl[7] = '{1'b1, 8'h78, 1'b0, 1'b1, 8'h56, 3'b010, 3'b100};
    tbl[8] = '{1'b0, 8'h78, 1'b0, 1'b0, 8'h00, 3'b000, 3'b100};
    repeat (2) @(negedge CLK);
    chk("rst_state", state, 3'b001);
    chk("rst_tag", tag, 0);
    chk("rst_req", BUS_req, 0);
    chk("rst_cmd", BUS_cmd, 0);
    chk("rst_addr", BUS_addr, 0);
    chk("rst_ready", CPU_ready, 0);
    CLR = 1;
    @(negedge CLK);
    for (int i = 0; i < 9; i++) xact(tbl[i]);
    v = '{1'b0, 8'h20, 1'b1, 1'b1, 8'h78, 3'b001, 3'b010};
    xact(v);
    CPU_valid = 1; CPU_wr = 1; CPU_tag = 8'h20;
    @(negedge CLK);
    chk("upg_cmd", BUS_cmd, 3'b011);
    chk("upg_req", BUS_req, 1);
    chk("upg_addr", BUS_addr, 8'h20);
    SNP_inv = 1;
    @(negedge CLK);
    SNP_inv = 0;
    chk("race_state", state, 3'b001);
    chk("race_cmd", BUS_cmd, 3'b010);
    chk("race_req", BUS_req, 1);
    BUS_gnt = 1;
    @(negedge CLK);
    BUS_gnt = 0; BUS_done = 1;
    @(negedge CLK);
    BUS_done = 0;
    chk("race_ready", CPU_ready, 1);
    chk("race_final", state, 3'b100);
    CPU_valid = 0;
    @(negedge CLK);
    SNP_shr = 1;
    @(negedge CLK);
    SNP_shr = 0;
    chk("shr_down", state, 3'b010);
    SNP_inv = 1; CPU_valid = 1; CPU_wr = 0; CPU_tag = 8'h20;
    @(negedge CLK);
    SNP_inv = 0;
    chk("inv_miss_state", state, 3'b001);
    chk("inv_miss_cmd", BUS_cmd, 3'b001);
    chk("inv_miss_req", BUS_req, 1);
    BUS_gnt = 1;
    @(negedge CLK);
    BUS_gnt = 0; BUS_done = 1; BUS_shared = 1;
    @(negedge CLK);
    BUS_done = 0; BUS_shared = 0;
    chk("inv_ready", CPU_ready, 1);
    chk("inv_fill", state, 3'b010);
    CPU_valid = 0;
    @(negedge CLK);
    CPU_valid = 1; CPU_wr = 0; CPU_tag = 8'h20;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk("b2b_ready", CPU_ready, (i % 2 == 0) ? 1 : 0);
    end
    CPU_valid = 0;
    @(negedge CLK);
    chk("b2b_end", CPU_ready, 0);
    CPU_valid = 1; CPU_tag = 8'h99;
    @(negedge CLK);
    chk("xr_req", BUS_req, 1);
    BUS_gnt = 1;
    @(negedge CLK);
    BUS_gnt = 0;
    #2 CLR = 0;
    #1;
    chk("ar_state", state, 3'b001);
    chk("ar_req", BUS_req, 0);
    chk("ar_cmd", BUS_cmd, 3'b000);
    chk("ar_ready", CPU_ready, 0);
    chk("ar_tag", tag, 0);
    CPU_valid = 0;
    @(negedge CLK);
    CLR = 1; BUS_done = 1;
    @(negedge CLK);
    BUS_done = 0;
    chk("done_ign_state", state, 3'b001);
    chk("done_ign_ready", CPU_ready, 0);
    chk("done_ign_req", BUS_req, 0);
    @(negedge CLK);
    chk("done_ign_ready2", CPU_ready, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/emissor.md
Name: emissor

Overview:
- Processor-side (requester) MESI controller for one cache line; counterpart of the bus-snooping listener.
- Accepts CPU read/write requests and decides hit/miss against a stored tag.
- On a miss or upgrade it issues bus transactions through a req/gnt/done handshake, including write-back of a dirty victim, and updates the line's MESI state.
- Applies snoop-driven downgrades from the listener between transactions.

Parameters:
- TAG_W, 8, tag width (bits) stored and compared per line.

Ports:
- CLK  in  1  clock, rising edge.
- CLR  in  1  reset, asynchronous, active-low.
- CPU_valid  in  1  CPU request present; held until CPU_ready.
- CPU_wr  in  1  1 = write, 0 = read; valid with CPU_valid.
- CPU_tag  in  TAG_W  request tag.
- CPU_ready  out  1  one-cycle pulse: request complete.
- BUS_req  out  1  bus request to arbiter.
- BUS_gnt  in  1  arbiter grant.
- BUS_cmd  out  3  000 none, 001 read miss, 010 write miss, 011 invalidate/upgrade, 100 write-back.
- BUS_addr  out  TAG_W  tag for the current command.
- BUS_done  in  1  transaction completion pulse.
- BUS_shared  in  1  another cache holds the line; sampled when BUS_done is high.
- SNP_inv  in  1  listener: invalidate line.
- SNP_shr  in  1  listener: downgrade E/M to S.
- state  out  3  line state: 001 I, 010 S, 011 E, 100 M.
- tag  out  TAG_W  stored tag.

Behaviour:
- Reset (CLR low, async):
  - state = 001, tag = 0.
  - Controller FSM to IDLE.
  - BUS_req = 0, BUS_cmd = 000, BUS_addr = 0, CPU_ready = 0.
  - Any in-flight request is dropped. The CPU must re-issue it.
- Controller FSM states: IDLE, WB_ARB, WB_XFER, ARB, XFER, RESP.
- Hit rule: hit = (state != 001) and (tag == CPU_tag).
- IDLE, snoops, highest priority:
  - SNP_inv: state -> 001.
  - else SNP_shr: E/M -> 010.
  - Snoops have no effect in I or S; SNP_inv has priority over SNP_shr.
  - If a snoop and CPU_valid arrive in the same cycle, the request is evaluated against the post-snoop state (combinational). Verify that an invalidated line misses.
- IDLE, request with CPU_valid = 1:
  - Read hit (S/E/M): -> RESP, state unchanged. CPU_ready is high the next cycle (latency 1).
  - Write hit in M: -> RESP.
  - Write hit in E: state -> M, -> RESP. No bus traffic.
  - Write hit in S: cmd 011 -> ARB.
  - Miss with state M: BUS_cmd = 100, BUS_addr = old tag -> WB_ARB.
  - Miss otherwise: cmd 001 (read) or 010 (write), BUS_addr = CPU_tag -> ARB.
- WB_ARB / ARB:
  - BUS_req = 1 and held until BUS_gnt is sampled high.
  - On grant: BUS_req = 0, go to the matching XFER state.
  - BUS_cmd and BUS_addr stay stable from ARB entry until BUS_done.
- WB_XFER, on BUS_done:
  - state -> 001.
  - Load the miss cmd (001/010) and BUS_addr = CPU_tag, -> ARB.
- XFER, on BUS_done:
  - Read miss: state = 011 if BUS_shared = 0, else 010.
  - Write miss or upgrade: state = 100.
  - tag = CPU_tag, BUS_cmd = 000, -> RESP.
- RESP: CPU_ready = 1 for one cycle, -> IDLE. A back-to-back request is accepted on the next cycle.
- Upgrade race: in ARB with cmd 011, if SNP_inv arrives before the grant:
  - state -> 001 and BUS_cmd is rewritten to 010 (write miss).
  - BUS_req stays high.
- Snoop inputs are ignored in WB_XFER/XFER (we own the bus) and in RESP.
- Snoops other than the upgrade race are ignored in ARB/WB_ARB. Tests must not rely on them.
- BUS_done outside XFER/WB_XFER: ignored.
- BUS_gnt while not requesting: ignored.

Optional Feature:
- Macro: EMISSOR_EXCL_EN.
- Defined: full MESI. A read miss with BUS_shared = 0 fills to E (011).
- Undefined: MSI mode. A read miss always fills to S (010) and BUS_shared is ignored. Because E is never entered, the write-hit-in-E path is unreachable.

Test Plan:
- Reset then read tag 0x12, BUS_gnt after 2 cycles, BUS_done with BUS_shared = 0 -> BUS_cmd 001 / BUS_addr 0x12, state 011 (010 without EMISSOR_EXCL_EN), CPU_ready one cycle after done.
- From E tag 0x12, write 0x12 -> no BUS_req, state 100, CPU_ready the next cycle. Then read 0x34 -> cmd 100 addr 0x12, then cmd 001 addr 0x34, final state 011 or 010 per BUS_shared.
- From S tag 0x20, write 0x20 -> cmd 011. Assert SNP_inv before grant -> cmd becomes 010, state 001; after done state 100.
- IDLE in M, SNP_shr -> state 010. Then SNP_inv together with read 0x20 -> treated as a miss, cmd 001.
- Drive CLR low during XFER -> immediately state 001, BUS_req 0, BUS_cmd 000, CPU_ready stays 0. A later BUS_done is ignored.
- Read miss with BUS_shared = 1 -> state 010 (both macro settings). Back-to-back read hits -> CPU_ready every other cycle.
